// File: rtl/race_frame_sequencer.sv
// Purpose : per-frame game controller: scroll, rival descent/respawn, collision hold, game over.
// Latency : every output is a register; inputs act on the next rising edge of clk.
// Backpr. : none; frame_tick/collision/start pulses arriving in states that ignore them are dropped.
//
// Ports:
//   clk, reset       100 MHz clock, synchronous active-high reset
//   start            single-cycle start/restart pulse (IDLE, GAMEOVER only)
//   frame_tick       one-cycle pulse per frame, advances the game
//   collision        level from the renderer, player/rival overlap
//   random           current LFSR value used for the rival lane offset
//   rand_next        one-cycle request to advance the LFSR
//   state            FSM encoding (IDLE 000, RUN 001, RESPAWN 010, COLLIDE 011, GAMEOVER 100)
//   stop             freeze request to the car FSM / scroller
//   scroll           background scroll offset, wraps mod 256
//   rival_x/rival_y  rival sprite position in screen pixels
//   score            rivals passed, saturating at 255
module race_frame_sequencer #(
    parameter int OFFSET_BG_X  = 200,
    parameter int OFFSET_BG_Y  = 150,
    parameter int BG_H         = 240,
    parameter int RIVAL_X_BASE = 20,
    parameter int RIVAL_STEP   = 2,
    parameter int SCROLL_STEP  = 1,
    parameter int COLLIDE_HOLD = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic [6:0] random,
    output logic       rand_next,
    output logic [2:0] state,
    output logic       stop,
    output logic [7:0] scroll,
    output logic [9:0] rival_x,
    output logic [9:0] rival_y,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        RUN      = 3'b001,
        RESPAWN  = 3'b010,
        COLLIDE  = 3'b011,
        GAMEOVER = 3'b100
    } fsm_t;

    localparam logic [9:0] X_HOME    = 10'(OFFSET_BG_X + RIVAL_X_BASE);
    localparam logic [9:0] Y_SPAWN   = 10'(OFFSET_BG_Y);
    localparam logic [9:0] Y_LIMIT   = 10'(OFFSET_BG_Y + BG_H);
    localparam logic [9:0] Y_STEP    = 10'(RIVAL_STEP);
    localparam logic [7:0] S_STEP    = 8'(SCROLL_STEP);
    localparam logic [7:0] HOLD_LAST = 8'(COLLIDE_HOLD);

    fsm_t       state_q, state_d;
    logic       phase_q, phase_d;      // RESPAWN: 0 = LFSR advance cycle, 1 = load cycle
    logic [7:0] hold_q, hold_d;
    logic [7:0] scroll_q, scroll_d;
    logic [9:0] rx_q, rx_d;
    logic [9:0] ry_q, ry_d;
    logic [7:0] score_q, score_d;
    logic       rn_q, rn_d;
    logic       stop_q, stop_d;
    logic [9:0] ry_step;
    logic [7:0] hold_inc;

    assign ry_step  = ry_q + Y_STEP;
    assign hold_inc = hold_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            hold_q   <= 8'd0;
            scroll_q <= 8'd0;
            rx_q     <= X_HOME;
            ry_q     <= Y_SPAWN;
            score_q  <= 8'd0;
            rn_q     <= 1'b0;
            stop_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            scroll_q <= scroll_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            score_q  <= score_d;
            rn_q     <= rn_d;
            stop_q   <= stop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        scroll_d = scroll_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        score_d  = score_q;
        rn_d     = 1'b0;

        case (state_q)
            IDLE, GAMEOVER: begin
                if (start) begin
                    state_d  = RUN;
                    scroll_d = 8'd0;
                    ry_d     = Y_SPAWN;
                    score_d  = 8'd0;
                end
            end
            RUN: begin
                if (collision) begin
                    // Collision wins over a coincident frame tick: nothing moves.
                    state_d = COLLIDE;
                    hold_d  = 8'd0;
                end else if (frame_tick) begin
                    scroll_d = scroll_q + S_STEP;
                    if (ry_step < Y_LIMIT) begin
                        ry_d = ry_step;
                    end else begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        state_d = RESPAWN;
                        phase_d = 1'b0;
                        // Registered so the request is high for the first RESPAWN cycle.
                        rn_d    = 1'b1;
                    end
                end
            end
            RESPAWN: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // The LFSR stepped at the end of the previous cycle; random is fresh.
                    rx_d    = X_HOME + {3'b000, random};
                    ry_d    = Y_SPAWN;
                    phase_d = 1'b0;
                    state_d = RUN;
                end
            end
            COLLIDE: begin
                if (frame_tick) begin
                    hold_d = hold_inc;
                    if (hold_inc == HOLD_LAST) begin
                        state_d = GAMEOVER;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Computed from the next state so stop switches on the same edge as state.
        stop_d = !((state_d == RUN) || (state_d == RESPAWN));
    end

    assign state     = state_q;
    assign stop      = stop_q;
    assign scroll    = scroll_q;
    assign rival_x   = rx_q;
    assign rival_y   = ry_q;
    assign score     = score_q;
    assign rand_next = rn_q;

endmodule
